wb_arb: RTL and testbench
=========================

// Module: wb_arb
// PURPOSE
//  Writeback-side arbiter: the consumer end of the producer->wb result interface.
//  Collects completed results from the ALU, MCALU and LSQ. Grants one per cycle,
//  round-robin. Drives the per-producer wb_*_stall back-pressure. Registers the winner
//  onto the single writeback bus to the ROB / result broadcast.
//  Sits between the execution units and the ROB.
// PARAMETERS
//  XLEN     32  result width
//  ROBID_W  7   ROB tag width
//  RD_W     6   physical dest register width
// PORTS
//  clk                          in   1        clock, all state on posedge
//  rst                          in   1        async, active-high reset
//  {alu,mcalu,lsq}_valid        in   1        producer result valid; held while stalled
//  {alu,mcalu,lsq}_error        in   1        exception flag
//  {alu,mcalu,lsq}_ecause       in   5        exception cause
//  {alu,mcalu,lsq}_robid        in   ROBID_W  ROB tag
//  {alu,mcalu,lsq}_rd           in   RD_W     dest register
//  {alu,mcalu,lsq}_result       in   XLEN     result data
//  wb_{alu,mcalu,lsq}_stall     out  1        back-pressure: producer must hold result
//  rob_flush                    in   1        pipeline flush (synchronous effect)
//  wb_valid                     out  1        writeback bus valid (registered)
//  wb_error / wb_ecause         out  1 / 5    registered exception info
//  wb_robid / wb_rd             out  ROBID_W / RD_W  registered tag / dest
//  wb_result                    out  XLEN     registered result
// BEHAVIOUR
//  - Reset (async, rst=1):
//    - wb_valid=0; wb_error, wb_ecause, wb_robid, wb_rd, wb_result = 0.
//    - RR pointer = ALU highest priority (priority order ALU>MCALU>LSQ).
//  - Source index: ALU=0, MCALU=1, LSQ=2.
//  - Grant (combinational): among sources with valid=1, choose the first in order
//    ptr, ptr+1, ptr+2 (mod 3). At most one grant per cycle.
//  - Stall: wb_X_stall = X_valid & ~grant_X. Never asserted when X_valid=0.
//    While rst or rob_flush is high: no grant, wb_X_stall = X_valid.
//  - Transfer: a source is consumed at the edge where X_valid=1 & wb_X_stall=0.
//  - Output stage:
//    - Winner's fields register onto wb_* at the next posedge (latency 1 cycle).
//    - wb_valid=1 for exactly one cycle per accepted result.
//    - The ROB always accepts; there is no stall into wb_arb.
//  - No grant in a cycle: wb_valid <= 0; data regs may hold stale values.
//  - RR update: on a grant to i, ptr <= (i+1) mod 3. ptr is unchanged when there is no grant.
//  - Fairness: a continuously valid source is granted within 3 cycles.
//  - Pass-through: error/ecause forwarded unmodified; error results arbitrate normally.
//  - rob_flush at an edge:
//    - wb_valid <= 0, which discards any registered result.
//    - No grant in the flush cycle; ptr unchanged.
//    - Producers clear themselves, so nothing is retained internally.
//  - Simultaneous: all three valid with ptr=0 -> grants ALU, MCALU, LSQ in successive
//    cycles, provided the inputs stay valid.
//  - Back-to-back from one source with no contention: one result per cycle, no bubbles.
//  - Reset mid-operation: wb_valid clears immediately (async); arbitration resumes
//    on the first edge after rst deasserts.
// TESTING
//  1. Reset: rst=1 with alu_valid=1 -> wb_valid=0, wb_alu_stall=1.
//     After release, the next edge gives wb_valid=1 with the ALU fields.
//  2. Single source: mcalu_valid=1, robid=7'h12, rd=6'h05, result=32'hDEADBEEF
//     -> no stall; next cycle wb_valid=1 with robid 12, rd 05, result DEADBEEF.
//  3. Three-way contention, all valid and held, ptr=0:
//     - Cycle 0: stalls MCALU=1, LSQ=1.
//     - wb_robid sequence is alu, mcalu, lsq over cycles 1..3.
//     - Each stall drops only on that source's grant cycle.
//  4. Fairness: ALU valid every cycle, LSQ valid from cycle 0 -> LSQ granted no later
//     than cycle 2; ALU never wins twice in a row while LSQ waits.
//  5. Flush: rob_flush=1 while ALU and LSQ are valid -> next cycle wb_valid=0 and no
//     grant; ptr is unchanged (checked by the post-flush grant order).
//  6. Error pass-through: lsq_error=1, ecause=5'd5 -> next cycle wb_error=1,
//     wb_ecause=5; wb_result equals lsq_result.

Source files
------------

// File: rtl/wb_arb_if.sv
// Producer->writeback result bus: three result producers in, one registered writeback bus out.
// Latency: none (signal bundle only).
// Backpressure: per-producer stall flows back toward the producers; the writeback bus never stalls.
interface wb_arb_if #(
    parameter int XLEN    = 32,
    parameter int ROBID_W = 7,
    parameter int RD_W    = 6
);
    // ALU result port
    logic               alu_valid;
    logic               alu_error;
    logic [4:0]         alu_ecause;
    logic [ROBID_W-1:0] alu_robid;
    logic [RD_W-1:0]    alu_rd;
    logic [XLEN-1:0]    alu_result;

    // MCALU result port
    logic               mcalu_valid;
    logic               mcalu_error;
    logic [4:0]         mcalu_ecause;
    logic [ROBID_W-1:0] mcalu_robid;
    logic [RD_W-1:0]    mcalu_rd;
    logic [XLEN-1:0]    mcalu_result;

    // LSQ result port
    logic               lsq_valid;
    logic               lsq_error;
    logic [4:0]         lsq_ecause;
    logic [ROBID_W-1:0] lsq_robid;
    logic [RD_W-1:0]    lsq_rd;
    logic [XLEN-1:0]    lsq_result;

    // back-pressure toward each producer
    logic               wb_alu_stall;
    logic               wb_mcalu_stall;
    logic               wb_lsq_stall;

    // pipeline flush from the ROB
    logic               rob_flush;

    // registered writeback bus toward the ROB / broadcast
    logic               wb_valid;
    logic               wb_error;
    logic [4:0]         wb_ecause;
    logic [ROBID_W-1:0] wb_robid;
    logic [RD_W-1:0]    wb_rd;
    logic [XLEN-1:0]    wb_result;

    // arbiter side
    modport slave (
        input  alu_valid, alu_error, alu_ecause, alu_robid, alu_rd, alu_result,
        input  mcalu_valid, mcalu_error, mcalu_ecause, mcalu_robid, mcalu_rd, mcalu_result,
        input  lsq_valid, lsq_error, lsq_ecause, lsq_robid, lsq_rd, lsq_result,
        input  rob_flush,
        output wb_alu_stall, wb_mcalu_stall, wb_lsq_stall,
        output wb_valid, wb_error, wb_ecause, wb_robid, wb_rd, wb_result
    );

    // producer / ROB side
    modport master (
        output alu_valid, alu_error, alu_ecause, alu_robid, alu_rd, alu_result,
        output mcalu_valid, mcalu_error, mcalu_ecause, mcalu_robid, mcalu_rd, mcalu_result,
        output lsq_valid, lsq_error, lsq_ecause, lsq_robid, lsq_rd, lsq_result,
        output rob_flush,
        input  wb_alu_stall, wb_mcalu_stall, wb_lsq_stall,
        input  wb_valid, wb_error, wb_ecause, wb_robid, wb_rd, wb_result
    );
endinterface

// File: rtl/wb_arb.sv
// Writeback arbiter: round-robin pick of one ALU/MCALU/LSQ result per cycle onto the writeback bus.
// Latency: 1 cycle from accepted producer result to wb_valid.
// Backpressure: losers (and everyone during rst/rob_flush) see stall = valid; the ROB side never stalls.
module wb_arb #(
    parameter int XLEN    = 32,
    parameter int ROBID_W = 7,
    parameter int RD_W    = 6
) (
    input  logic      clk,
    input  logic      rst,
    wb_arb_if.slave   bus
);

    localparam int NSRC = 3;

    // Source indices double as the fixed tie order ALU > MCALU > LSQ when ptr = 0.
    localparam logic [1:0] SRC_ALU   = 2'd0;
    localparam logic [1:0] SRC_MCALU = 2'd1;
    localparam logic [1:0] SRC_LSQ   = 2'd2;

    typedef struct packed {
        logic               error;
        logic [4:0]         ecause;
        logic [ROBID_W-1:0] robid;
        logic [RD_W-1:0]    rd;
        logic [XLEN-1:0]    result;
    } res_t;

    logic [NSRC-1:0] req;
    res_t            src [NSRC];
    logic            blk;
    logic [1:0]      ptr;
    logic [1:0]      idx;
    logic [1:0]      win_idx;
    logic            any_gnt;
    logic [NSRC-1:0] gnt;
    res_t            sel;
    res_t            wb_q;
    logic            wb_valid_q;

    // (base + off) mod 3 for values in 0..2; also folds a stray 3 back to 0.
    function automatic logic [1:0] rr_idx(input logic [1:0] base, input logic [1:0] off);
        logic [2:0] s;
        s = {1'b0, base} + {1'b0, off};
        if (s >= 3'd3) begin
            s = s - 3'd3;
        end
        return s[1:0];
    endfunction

    assign req[SRC_ALU]   = bus.alu_valid;
    assign req[SRC_MCALU] = bus.mcalu_valid;
    assign req[SRC_LSQ]   = bus.lsq_valid;

    assign src[SRC_ALU]   = '{error: bus.alu_error, ecause: bus.alu_ecause, robid: bus.alu_robid,
                              rd: bus.alu_rd, result: bus.alu_result};
    assign src[SRC_MCALU] = '{error: bus.mcalu_error, ecause: bus.mcalu_ecause, robid: bus.mcalu_robid,
                              rd: bus.mcalu_rd, result: bus.mcalu_result};
    assign src[SRC_LSQ]   = '{error: bus.lsq_error, ecause: bus.lsq_ecause, robid: bus.lsq_robid,
                              rd: bus.lsq_rd, result: bus.lsq_result};

    // Nothing may transfer while reset or a flush is in progress.
    assign blk = rst | bus.rob_flush;

    // Round-robin grant: scan ptr, ptr+1, ptr+2 and take the first requester.
    always_comb begin
        gnt     = '0;
        any_gnt = 1'b0;
        win_idx = 2'd0;
        idx     = 2'd0;
        if (!blk) begin
            for (int k = 0; k < NSRC; k++) begin
                idx = rr_idx(ptr, 2'(k));
                if (!any_gnt && req[idx]) begin
                    any_gnt      = 1'b1;
                    win_idx      = idx;
                    gnt[idx]     = 1'b1;
                end
            end
        end
    end

    assign sel = src[win_idx];

    // A producer holds its result whenever it asks and is not the winner.
    assign bus.wb_alu_stall   = req[SRC_ALU]   & ~gnt[SRC_ALU];
    assign bus.wb_mcalu_stall = req[SRC_MCALU] & ~gnt[SRC_MCALU];
    assign bus.wb_lsq_stall   = req[SRC_LSQ]   & ~gnt[SRC_LSQ];

    // Priority pointer moves just past the winner; it holds on idle and flush cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= SRC_ALU;
        end else if (any_gnt) begin
            ptr <= rr_idx(win_idx, 2'd1);
        end
    end

    // Writeback valid pulses once per accepted result; a flush cycle has no grant, so it drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid_q <= 1'b0;
        end else begin
            wb_valid_q <= any_gnt;
        end
    end

    // Writeback payload captures the winner's fields; left stale when nothing is granted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_q <= '0;
        end else if (any_gnt) begin
            wb_q <= sel;
        end
    end

    assign bus.wb_valid  = wb_valid_q;
    assign bus.wb_error  = wb_q.error;
    assign bus.wb_ecause = wb_q.ecause;
    assign bus.wb_robid  = wb_q.robid;
    assign bus.wb_rd     = wb_q.rd;
    assign bus.wb_result = wb_q.result;

endmodule

// File: tb/tb_wb_arb.sv
// Bench for wb_arb: directed scenarios followed by randomized producer/flush/reset traffic.
// Latency: expects writeback one cycle after the accepting edge.
// Backpressure: producers hold their result while their stall is high.
module tb_wb_arb;

    localparam int XLEN    = 32;
    localparam int ROBID_W = 7;
    localparam int RD_W    = 6;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    wb_arb_if #(.XLEN(XLEN), .ROBID_W(ROBID_W), .RD_W(RD_W)) bus ();

    wb_arb #(.XLEN(XLEN), .ROBID_W(ROBID_W), .RD_W(RD_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // producer-side state, index 0=ALU 1=MCALU 2=LSQ
    logic               p_valid [3];
    logic               p_err   [3];
    logic [4:0]         p_ec    [3];
    logic [ROBID_W-1:0] p_robid [3];
    logic [RD_W-1:0]    p_rd    [3];
    logic [XLEN-1:0]    p_res   [3];
    logic               flush;
    logic               stall   [3];

    assign bus.alu_valid    = p_valid[0];
    assign bus.alu_error    = p_err[0];
    assign bus.alu_ecause   = p_ec[0];
    assign bus.alu_robid    = p_robid[0];
    assign bus.alu_rd       = p_rd[0];
    assign bus.alu_result   = p_res[0];
    assign bus.mcalu_valid  = p_valid[1];
    assign bus.mcalu_error  = p_err[1];
    assign bus.mcalu_ecause = p_ec[1];
    assign bus.mcalu_robid  = p_robid[1];
    assign bus.mcalu_rd     = p_rd[1];
    assign bus.mcalu_result = p_res[1];
    assign bus.lsq_valid    = p_valid[2];
    assign bus.lsq_error    = p_err[2];
    assign bus.lsq_ecause   = p_ec[2];
    assign bus.lsq_robid    = p_robid[2];
    assign bus.lsq_rd       = p_rd[2];
    assign bus.lsq_result   = p_res[2];
    assign bus.rob_flush    = flush;

    assign stall[0] = bus.wb_alu_stall;
    assign stall[1] = bus.wb_mcalu_stall;
    assign stall[2] = bus.wb_lsq_stall;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: last granted source and the expected writeback bus.
    int                 last = 2;
    bit                 exp_v = 1'b0;
    logic               exp_err = 1'b0;
    logic [4:0]         exp_ec = '0;
    logic [ROBID_W-1:0] exp_robid = '0;
    logic [RD_W-1:0]    exp_rd = '0;
    logic [XLEN-1:0]    exp_res = '0;
    int                 wait_c [3] = '{0, 0, 0};

    task automatic load(input int i, input logic e, input logic [4:0] ec,
                        input logic [ROBID_W-1:0] robid, input logic [RD_W-1:0] rd,
                        input logic [XLEN-1:0] res);
        p_valid[i] = 1'b1;
        p_err[i]   = e;
        p_ec[i]    = ec;
        p_robid[i] = robid;
        p_rd[i]    = rd;
        p_res[i]   = res;
    endtask

    // One clock: check at the falling edge, advance the model, release consumed producers.
    task automatic step();
        int win;
        bit blk;
        @(negedge clk);
        blk = rst || flush;
        if (rst) begin
            exp_v = 1'b0; exp_err = 1'b0; exp_ec = '0;
            exp_robid = '0; exp_rd = '0; exp_res = '0;
        end
        win = -1;
        if (!blk) begin
            for (int k = 1; k <= 3; k++) begin
                automatic int i = (last + k) % 3;
                if (win < 0 && p_valid[i]) win = i;
            end
        end
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("stall%0d", i), 64'(stall[i]), 64'(p_valid[i] && (i != win)));
        end
        chk("wb_valid", 64'(bus.wb_valid), 64'(exp_v));
        if (exp_v || rst) begin
            chk("wb_error",  64'(bus.wb_error),  64'(exp_err));
            chk("wb_ecause", 64'(bus.wb_ecause), 64'(exp_ec));
            chk("wb_robid",  64'(bus.wb_robid),  64'(exp_robid));
            chk("wb_rd",     64'(bus.wb_rd),     64'(exp_rd));
            chk("wb_result", 64'(bus.wb_result), 64'(exp_res));
        end
        for (int i = 0; i < 3; i++) begin
            if (!blk && p_valid[i] && i != win && stall[i]) wait_c[i]++;
            else wait_c[i] = 0;
            chk($sformatf("fair%0d", i), 64'(wait_c[i] < 3), 64'd1);
        end
        if (rst) begin
            last = 2;
        end else if (win >= 0) begin
            exp_v = 1'b1; exp_err = p_err[win]; exp_ec = p_ec[win];
            exp_robid = p_robid[win]; exp_rd = p_rd[win]; exp_res = p_res[win];
            last = win;
        end else begin
            exp_v = 1'b0;
        end
        @(posedge clk);
        #1;
        if (win >= 0) p_valid[win] = 1'b0;
    endtask

    initial begin
        int lsq_cyc;
        for (int i = 0; i < 3; i++) begin
            p_valid[i] = 1'b0; p_err[i] = 1'b0; p_ec[i] = '0;
            p_robid[i] = '0; p_rd[i] = '0; p_res[i] = '0;
        end
        flush = 1'b0;
        #1 rst = 1'b1;

        // reset with ALU valid, then release
        load(0, 1'b0, 5'd0, 7'h21, 6'h01, 32'h1111_0000);
        #1;
        chk("t1_rst_wb_valid", 64'(bus.wb_valid), 64'd0);
        chk("t1_rst_alu_stall", 64'(bus.wb_alu_stall), 64'd1);
        step();
        rst = 1'b0;
        step();
        chk("t1_valid", 64'(bus.wb_valid), 64'd1);
        chk("t1_robid", 64'(bus.wb_robid), 64'h21);

        // single MCALU source
        load(1, 1'b0, 5'd0, 7'h12, 6'h05, 32'hDEADBEEF);
        #1;
        chk("t2_stall", 64'(bus.wb_mcalu_stall), 64'd0);
        step();
        chk("t2_robid", 64'(bus.wb_robid), 64'h12);
        chk("t2_rd", 64'(bus.wb_rd), 64'h05);
        chk("t2_result", 64'(bus.wb_result), 64'hDEADBEEF);
        step();

        // three-way contention from ptr=0
        rst = 1'b1;
        step();
        rst = 1'b0;
        load(0, 1'b0, 5'd0, 7'h30, 6'h10, 32'hA0A0_0000);
        load(1, 1'b0, 5'd0, 7'h31, 6'h11, 32'hA1A1_0001);
        load(2, 1'b0, 5'd0, 7'h32, 6'h12, 32'hA2A2_0002);
        #1;
        chk("t3_c0_mcalu_stall", 64'(bus.wb_mcalu_stall), 64'd1);
        chk("t3_c0_lsq_stall", 64'(bus.wb_lsq_stall), 64'd1);
        step();
        chk("t3_c1_robid", 64'(bus.wb_robid), 64'h30);
        step();
        chk("t3_c2_robid", 64'(bus.wb_robid), 64'h31);
        step();
        chk("t3_c3_robid", 64'(bus.wb_robid), 64'h32);

        // fairness: ALU refilled every cycle, LSQ waiting
        lsq_cyc = -1;
        load(2, 1'b0, 5'd0, 7'h44, 6'h20, 32'h4444_4444);
        for (int c = 0; c < 4; c++) begin
            if (!p_valid[0]) load(0, 1'b0, 5'd0, 7'(8'h40 + c), 6'h21, 32'h4000_0000 + c);
            #1;
            if (lsq_cyc < 0 && p_valid[2] && !bus.wb_lsq_stall) lsq_cyc = c;
            step();
        end
        chk("t4_lsq_by_c2", 64'(lsq_cyc >= 0 && lsq_cyc <= 2), 64'd1);

        // flush keeps the pointer: after ALU wins, flush, then LSQ must win before ALU
        rst = 1'b1;
        step();
        rst = 1'b0;
        load(0, 1'b0, 5'd0, 7'h50, 6'h30, 32'h5000_0000);
        step();
        load(0, 1'b0, 5'd0, 7'h51, 6'h31, 32'h5100_0001);
        load(2, 1'b0, 5'd0, 7'h52, 6'h32, 32'h5200_0002);
        flush = 1'b1;
        #1;
        chk("t5_flush_alu_stall", 64'(bus.wb_alu_stall), 64'd1);
        chk("t5_flush_lsq_stall", 64'(bus.wb_lsq_stall), 64'd1);
        step();
        chk("t5_flush_wb_valid", 64'(bus.wb_valid), 64'd0);
        flush = 1'b0;
        step();
        chk("t5_post_first", 64'(bus.wb_robid), 64'h52);
        step();
        chk("t5_post_second", 64'(bus.wb_robid), 64'h51);

        // error pass-through from the LSQ
        load(2, 1'b1, 5'd5, 7'h60, 6'h03, 32'hCAFE_0006);
        step();
        chk("t6_error", 64'(bus.wb_error), 64'd1);
        chk("t6_ecause", 64'(bus.wb_ecause), 64'd5);
        chk("t6_result", 64'(bus.wb_result), 64'hCAFE_0006);
        step();

        // randomized traffic with occasional flush and reset
        for (int n = 0; n < 800; n++) begin
            for (int i = 0; i < 3; i++) begin
                if (!p_valid[i] && $urandom_range(0, 2) != 0) begin
                    load(i, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                         7'($urandom_range(0, 127)), 6'($urandom_range(0, 63)), 32'($urandom));
                end
            end
            flush = ($urandom_range(0, 15) == 0);
            rst   = ($urandom_range(0, 63) == 0);
            step();
            if (flush) begin
                for (int i = 0; i < 3; i++) begin
                    if ($urandom_range(0, 1) == 1) p_valid[i] = 1'b0;
                end
            end
        end
        flush = 1'b0;
        rst   = 1'b0;
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
